rr_arbiter8: RTL and testbench
==============================

# rr_arbiter8

Eight-requester round-robin arbiter with grant hold and hold-time limit. It shares one downstream resource, such as a bus slot or a shared datapath unit, among eight requesters. Requesters are ranked by a rotating priority pointer and scanned with an 8→3 priority-encode search. Outputs are registered: a one-hot grant, the binary index of the granted requester, and a timeout pulse when a grant is forcibly revoked.

## Interface
Parameters
- MAX_HOLD, 4, maximum consecutive cycles one grant stays asserted; legal range 0..255; 0 = unlimited

Ports
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- en  input  1  arbiter enable; 0 = no new grants, and any active grant is dropped
- req  input  8  request vector; bit i = requester i wants the resource
- gnt  output  8  one-hot grant; all zero when nothing is granted
- gnt_idx  output  3  binary index of the granted requester; 0 when idle
- gnt_valid  output  1  1 while any grant is active (equals |gnt)
- timeout  output  1  one-cycle pulse, asserted in the cycle after a grant is revoked by the MAX_HOLD limit

## Operation
- State machine: IDLE and GRANT.
- Internal registers:
  - ptr[2:0], the highest-priority position
  - hold_cnt[7:0]
  - idx[2:0]
- Search: starting at bit ptr, scan upward through req with wrap (ptr, ptr+1, …, 7, 0, …, ptr−1). The first set bit wins.
- IDLE:
  - If en=1 and req≠0, load idx with the search result, go to GRANT, and set hold_cnt=1.
  - Otherwise stay in IDLE.
- GRANT is evaluated every edge, with conditions in priority order:
  1. If en=0 or req[idx]=0: release and go to IDLE. timeout stays 0.
  2. Else if MAX_HOLD≠0 and hold_cnt==MAX_HOLD: release, go to IDLE, and set timeout=1 for one cycle.
  3. Else: hold, and increment hold_cnt (saturating at 255).
- On release, ptr ← (idx+1) mod 8, so 7 wraps to 0. ptr is not updated at any other time.
- A release always passes through IDLE. There is at least one idle cycle (gnt=0) between consecutive grants, including a re-grant to the same requester.
- Requests that rise or fall while another requester is granted have no effect until the next IDLE evaluation.
- Outputs in GRANT: gnt=1<<idx, gnt_idx=idx, gnt_valid=1. Outputs in IDLE: gnt=0, gnt_idx=0, gnt_valid=0.

## Timing
- Reset (rst_n=0, asynchronous, effective immediately):
  - state=IDLE, ptr=0, idx=0, hold_cnt=0
  - gnt=8'h00, gnt_idx=0, gnt_valid=0, timeout=0
- Reset in the middle of a grant drops the grant at once, without a timeout pulse. ptr returns to 0.
- Grant latency: a request seen in IDLE at edge k gives gnt asserted from edge k (registered). That is one cycle after req is presented to an idle arbiter.
- Maximum grant width is MAX_HOLD cycles. With MAX_HOLD=0, a grant lasts as long as req[idx] and en stay high.
- Release latency: req[idx] or en falling before edge k clears gnt at edge k.
- timeout rises at the same edge that clears gnt, and falls at the next edge.
- Fairness bound: with all eight requesting continuously and MAX_HOLD=M>0, every requester is granted within 8·(M+1) cycles.

## Test plan
- Reset: assert rst_n=0 mid-simulation during an active grant → all outputs 0 immediately, no timeout. After release, req=8'h80 → gnt=8'h80, gnt_idx=7 one cycle later.
- Single requester: req=8'h04 held 2 cycles then dropped, MAX_HOLD=4 → gnt=8'h04 and gnt_idx=2 for exactly 2 cycles, then 0, timeout=0, ptr becomes 3.
- Rotation: req=8'hFF held continuously, MAX_HOLD=4 → grants idx 0,1,2,…,7,0. Each grant is 4 cycles, followed by a 1-cycle gap. timeout pulses after each grant.
- Wrap and skip: ptr=7 (just after granting 6), req=8'b0100_0001 → next grant idx 0 (bit 7 clear, wraps past it). After release, with the same req, the next grant is idx 6.
- Enable: en=0 with req=8'h10 → no grant. en=1 → gnt=8'h10 next cycle. Dropping en mid-grant → gnt=0 at the next edge, timeout=0.
- Unlimited hold: MAX_HOLD=0, req=8'h01 held 300 cycles → gnt=8'h01 for all 300 cycles, hold_cnt saturates at 255, timeout never asserts.

Source files
------------

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with grant hold and a hold-time limit.
// Grants are registered; a rotating pointer ranks requesters after each release.
module rr_arbiter8 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_MAX = 8'(MAX_HOLD);
    localparam logic       HOLD_LIM = (MAX_HOLD != 0);

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] idx_q, idx_d;
    logic [7:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;

    logic [15:0] req_dbl;
    logic [7:0]  req_rot;
    logic [2:0]  win_off;
    logic [2:0]  win_idx;
    logic        idx_req;

    // Rotate req so the pointer position lands on bit 0.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr_q +: 8];

    // Lowest set bit of the rotated vector is the first hit from ptr upward.
    always_comb begin
        win_off = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (req_rot[i]) begin
                win_off = 3'(i);
            end
        end
    end

    assign win_idx = ptr_q + win_off;
    assign idx_req = req[idx_q];

    // Next-state logic: grant from IDLE, release or hold from GRANT.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        hold_d    = hold_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (en && (req != 8'h00)) begin
                    idx_d   = win_idx;
                    hold_d  = 8'd1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (!en || !idx_req) begin
                    ptr_d   = idx_q + 3'd1;
                    state_d = IDLE;
                end else if (HOLD_LIM && (hold_q == HOLD_MAX)) begin
                    ptr_d     = idx_q + 3'd1;
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 3'd0;
            idx_q     <= 3'd0;
            hold_q    <= 8'd0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_valid = (state_q == GRANT);
    assign gnt       = gnt_valid ? (8'h01 << idx_q) : 8'h00;
    assign gnt_idx   = gnt_valid ? idx_q : 3'd0;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed scenarios plus random traffic,
// checked against a cycle model of the arbitration rules.
module tb_rr_arbiter8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] req = 8'h00;

    logic [7:0] gnt_a, gnt_b;
    logic [2:0] idx_a, idx_b;
    logic       v_a, v_b, to_a, to_b;
    logic [12:0] obs [2];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    int m_gnt [2];
    int m_ptr [2];
    int m_hold [2];
    bit m_to [2];
    int mh [2] = '{4, 0};

    rr_arbiter8 #(.MAX_HOLD(4)) u_a (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt_a), .gnt_idx(idx_a), .gnt_valid(v_a), .timeout(to_a)
    );

    rr_arbiter8 #(.MAX_HOLD(0)) u_b (
        .clk(clk), .rst_n(rst_n), .en(en), .req(req),
        .gnt(gnt_b), .gnt_idx(idx_b), .gnt_valid(v_b), .timeout(to_b)
    );

    assign obs[0] = {gnt_a, idx_a, v_a, to_a};
    assign obs[1] = {gnt_b, idx_b, v_b, to_b};

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            m_gnt[u] = -1;
            m_ptr[u] = 0;
            m_hold[u] = 0;
            m_to[u] = 1'b0;
        end
    endtask

    task automatic model_edge(int u);
        bit found;
        int j;
        m_to[u] = 1'b0;
        if (m_gnt[u] < 0) begin
            if (en && req != 8'h00) begin
                found = 1'b0;
                for (int k = 0; k < 8; k++) begin
                    j = (m_ptr[u] + k) % 8;
                    if (!found && req[j]) begin
                        m_gnt[u] = j;
                        found = 1'b1;
                    end
                end
                m_hold[u] = 1;
            end
        end else if (!en || !req[m_gnt[u]]) begin
            m_ptr[u] = (m_gnt[u] + 1) % 8;
            m_gnt[u] = -1;
        end else if (mh[u] != 0 && m_hold[u] == mh[u]) begin
            m_ptr[u] = (m_gnt[u] + 1) % 8;
            m_gnt[u] = -1;
            m_to[u] = 1'b1;
        end else if (m_hold[u] < 255) begin
            m_hold[u]++;
        end
    endtask

    function automatic logic [12:0] exp_pack(int u);
        logic [7:0] g;
        if (m_gnt[u] < 0) return {8'h00, 3'd0, 1'b0, m_to[u]};
        g = 8'h01 << m_gnt[u];
        return {g, 3'(m_gnt[u]), 1'b1, m_to[u]};
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            model_edge(0);
            model_edge(1);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            total++;
            if (obs[u] !== 13'h0) begin
                bad++;
                $display("FAIL reset_init u%0d got=%h want=0", u, obs[u]);
            end
        end
        rst_n = 1'b1;
        en = 1'b1;
        req = 8'h3C;
        tick();
        tick();
        total++;
        if (obs[0] !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_pre_grant got=%h want=%h",
                     obs[0], {8'h04, 3'd2, 1'b1, 1'b0});
        end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int u = 0; u < 2; u++) begin
            total++;
            if (obs[u] !== 13'h0) begin
                bad++;
                $display("FAIL reset_mid_grant u%0d got=%h want=0", u, obs[u]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        req = 8'h80;
        tick();
        total++;
        if (obs[0] !== {8'h80, 3'd7, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL reset_after_req80 got=%h want=%h",
                     obs[0], {8'h80, 3'd7, 1'b1, 1'b0});
        end
    endtask

    task automatic test_single();
        apply_reset();
        en = 1'b1;
        req = 8'h04;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (obs[0] !== {8'h04, 3'd2, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL single_hold c%0d got=%h want=%h",
                         i, obs[0], {8'h04, 3'd2, 1'b1, 1'b0});
            end
        end
        req = 8'h00;
        tick();
        total++;
        if (obs[0] !== 13'h0) begin
            bad++;
            $display("FAIL single_release got=%h want=0", obs[0]);
        end
        tick();
        req = 8'h09;
        tick();
        total++;
        if (obs[0] !== {8'h08, 3'd3, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL single_ptr3 got=%h want=%h",
                     obs[0], {8'h08, 3'd3, 1'b1, 1'b0});
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_rotation();
        int seq[$];
        bit prev_v;
        int run;
        apply_reset();
        en = 1'b1;
        req = 8'hFF;
        prev_v = 1'b0;
        run = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            for (int u = 0; u < 2; u++) begin
                total++;
                if (obs[u] !== exp_pack(u)) begin
                    bad++;
                    $display("FAIL rotation_model u%0d cyc%0d got=%h want=%h",
                             u, cyc, obs[u], exp_pack(u));
                end
            end
            if (v_a && !prev_v) seq.push_back(int'(idx_a));
            if (v_a) run++;
            if (!v_a && prev_v) begin
                total++;
                if (run != 4 || to_a !== 1'b1) begin
                    bad++;
                    $display("FAIL rotation_width got=%0d/to%b want=4/to1",
                             run, to_a);
                end
                run = 0;
            end
            prev_v = v_a;
        end
        total++;
        if (seq.size() < 9) begin
            bad++;
            $display("FAIL rotation_count got=%0d want>=9", seq.size());
        end else begin
            for (int k = 0; k < 9; k++) begin
                total++;
                if (seq[k] != k % 8) begin
                    bad++;
                    $display("FAIL rotation_order k%0d got=%0d want=%0d",
                             k, seq[k], k % 8);
                end
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_wrap();
        apply_reset();
        en = 1'b1;
        req = 8'h40;
        tick();
        tick();
        req = 8'h00;
        tick();
        req = 8'h41;
        tick();
        total++;
        if (obs[0] !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL wrap_to0 got=%h want=%h",
                     obs[0], {8'h01, 3'd0, 1'b1, 1'b0});
        end
        repeat (3) tick();
        tick();
        total++;
        if (obs[0] !== {8'h00, 3'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL wrap_timeout got=%h want=%h",
                     obs[0], {8'h00, 3'd0, 1'b0, 1'b1});
        end
        tick();
        total++;
        if (obs[0] !== {8'h40, 3'd6, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL wrap_to6 got=%h want=%h",
                     obs[0], {8'h40, 3'd6, 1'b1, 1'b0});
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_enable();
        apply_reset();
        en = 1'b0;
        req = 8'h10;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (obs[0] !== 13'h0) begin
                bad++;
                $display("FAIL enable_off c%0d got=%h want=0", i, obs[0]);
            end
        end
        en = 1'b1;
        tick();
        total++;
        if (obs[0] !== {8'h10, 3'd4, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL enable_on got=%h want=%h",
                     obs[0], {8'h10, 3'd4, 1'b1, 1'b0});
        end
        tick();
        en = 1'b0;
        tick();
        for (int u = 0; u < 2; u++) begin
            total++;
            if (obs[u] !== 13'h0) begin
                bad++;
                $display("FAIL enable_drop u%0d got=%h want=0", u, obs[u]);
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_unlimited();
        apply_reset();
        en = 1'b1;
        req = 8'h01;
        for (int i = 0; i < 300; i++) begin
            tick();
            total++;
            if (obs[1] !== {8'h01, 3'd0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL unlimited_hold c%0d got=%h want=%h",
                         i, obs[1], {8'h01, 3'd0, 1'b1, 1'b0});
            end
            total++;
            if (obs[0] !== exp_pack(0)) begin
                bad++;
                $display("FAIL unlimited_model_a c%0d got=%h want=%h",
                         i, obs[0], exp_pack(0));
            end
        end
        req = 8'h00;
        tick();
    endtask

    task automatic test_random();
        apply_reset();
        en = 1'b1;
        req = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 2) == 0) req = 8'($urandom & $urandom);
            en = ($urandom_range(0, 15) != 0);
            tick();
            for (int u = 0; u < 2; u++) begin
                total++;
                if (obs[u] !== exp_pack(u)) begin
                    bad++;
                    $display("FAIL random_model u%0d cyc%0d got=%h want=%h",
                             u, cyc, obs[u], exp_pack(u));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap();
        test_enable();
        test_unlimited();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
